nibble_serial_cmp_ctrl: RTL
===========================

Name: nibble_serial_cmp_ctrl

Overview:
Sequencing controller that compares two WIDTH-bit operands using one shared 4-bit magnitude-compare unit, one nibble per clock.
- Scan order: MSB nibble first.
- Terminates early at the first unequal nibble.
- Operands and results use valid/ready handshakes.
- Intended for wide compares where replicating a full-width comparator is not justified.

Parameters:
- WIDTH, 16, operand width in bits; must be a multiple of 4 and at least 4.
- NIB, WIDTH/4, derived nibble count; not overridable.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start_valid  input  1  operands a_in/b_in present.
- start_ready  output  1  controller can accept operands.
- a_in  input  WIDTH  operand A.
- b_in  input  WIDTH  operand B.
- res_valid  output  1  result flags valid.
- res_ready  input  1  consumer accepts result.
- a_grt_b  output  1  A > B.
- a_less_b  output  1  A < B.
- a_eq_b  output  1  A == B.
- cmp_cycles  output  $clog2(NIB)+1  number of nibbles examined for the current result (1..NIB).
- busy  output  1  high in SCAN or DONE.

Behaviour:
- Reset (asynchronous, active-high, effective immediately):
  - state=IDLE; a_grt_b, a_less_b, a_eq_b, cmp_cycles, res_valid all 0.
  - busy=0, start_ready=1.
- States: IDLE, SCAN, DONE. start_ready=(state==IDLE); res_valid=(state==DONE); busy=(state!=IDLE).
- IDLE:
  - On start_valid&&start_ready: latch a_in/b_in into internal registers, nibble index idx=NIB-1, count=0, go SCAN.
  - Otherwise stay in IDLE.
- SCAN, each cycle:
  - The 4-bit unit compares A[4*idx+:4] with B[4*idx+:4]; count increments.
  - If gt or lt: load the flags (exactly one set), cmp_cycles=count+1, go DONE.
  - If eq and idx==0: set a_eq_b only, cmp_cycles=NIB, go DONE.
  - If eq and idx>0: idx decrements, stay in SCAN.
- Latency: operand accept edge to res_valid high = k clocks, where k = nibbles examined (1..NIB).
- DONE:
  - res_valid=1; flags and cmp_cycles held stable until res_ready.
  - On res_valid&&res_ready, go IDLE.
- Flags and cmp_cycles:
  - Retain their last values in IDLE.
  - Overwritten only when the next result is loaded.
  - Exactly one flag is high whenever res_valid=1.
- Busy handling: start_valid while not in IDLE is ignored; operands are not captured and no state changes.
- res_ready and start_valid high together in DONE: result handshake completes; the new start is accepted no earlier than the following cycle in IDLE.
- a_in/b_in changes after acceptance have no effect on the operation in flight.
- Reset mid-SCAN or mid-DONE: the operation is aborted, no result is produced, and all outputs take their reset values.

Optional Feature:
- Macro SIGNED_CMP_EN.
- Defined: operands are two's complement. When comparing the MSB nibble (idx==NIB-1), bit 3 of both nibbles is inverted before the 4-bit compare; all other nibbles compare unsigned.
- Undefined: pure unsigned compare at every nibble.
- Latency and handshakes are identical in both builds.

Decomposition:
- Package cmp_pkg:
  - state enum (IDLE, SCAN, DONE).
  - NIB_W function/constant for the idx/count widths.
  - NIBBLE=4 constant.
- Sub-module cmp4_unit: combinational 4-bit compare with outputs gt, lt, eq; instantiated once.
- The controller holds the FSM, operand registers, idx, count and result registers.

Test Plan:
- Default WIDTH=16 throughout.
- A=0xA000, B=0x0000 -> res_valid after 1 clock; a_grt_b=1, others 0; cmp_cycles=1.
- A=0x1234, B=0x1235 -> res_valid after 4 clocks; a_less_b=1; cmp_cycles=4.
- A=B=0xFFFF -> res_valid after 4 clocks; a_eq_b=1; cmp_cycles=4.
- A=0x3C00, B=0x3B00 with res_ready held low for 5 cycles:
  - a_grt_b=1, cmp_cycles=2.
  - res_valid and flags stable throughout; start_ready=0.
  - A start_valid pulse during the stall is ignored.
  - After res_ready, IDLE in 1 cycle.
- A=0x1111, B=0x1112, rst asserted mid-SCAN (2nd SCAN cycle) -> all outputs 0 immediately, start_ready=1. A following compare of 0x0005 vs 0x0003 gives a_grt_b=1, cmp_cycles=4.
- A=0x8000, B=0x0001:
  - With SIGNED_CMP_EN: a_less_b=1, cmp_cycles=1.
  - Without: a_grt_b=1, cmp_cycles=1.

Source files
------------

// File: rtl/cmp_pkg.sv
// cmp_pkg: shared types and constants for the nibble-serial comparator.
package cmp_pkg;
  localparam int NIBBLE = 4;
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_e;
  function automatic int nib_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/cmp4_unit.sv
// cmp4_unit: combinational 4-bit unsigned magnitude compare.
module cmp4_unit
  import cmp_pkg::*;
(
  input  logic [NIBBLE-1:0] a,
  input  logic [NIBBLE-1:0] b,
  output logic              gt,
  output logic              lt,
  output logic              eq
);
  assign gt = a > b;
  assign lt = a < b;
  assign eq = a == b;
endmodule

// File: rtl/nibble_serial_cmp_ctrl.sv
// nibble_serial_cmp_ctrl: MSB-first nibble-serial compare with early exit.
// Define SIGNED_CMP_EN for two's complement operands.
module nibble_serial_cmp_ctrl
  import cmp_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start_valid,
  output logic                            start_ready,
  input  logic [WIDTH-1:0]                a_in,
  input  logic [WIDTH-1:0]                b_in,
  output logic                            res_valid,
  input  logic                            res_ready,
  output logic                            a_grt_b,
  output logic                            a_less_b,
  output logic                            a_eq_b,
  output logic [$clog2(WIDTH/4):0]        cmp_cycles,
  output logic                            busy
);
  localparam int NIB = WIDTH / NIBBLE;
  localparam int IW = nib_w(NIB);
  localparam int CW = $clog2(NIB) + 1;
  state_e state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d, cyc_q, cyc_d;
  logic gt_q, gt_d, lt_q, lt_d, eq_q, eq_d;
  logic [NIBBLE-1:0] a_nib, b_nib;
  logic gt, lt, eq;
`ifdef SIGNED_CMP_EN
  // Flipping the sign bit maps two's complement order onto unsigned order.
  logic msb;
  assign msb = idx_q == IW'(NIB - 1);
  assign a_nib = a_q[NIBBLE*idx_q +: NIBBLE] ^ {msb, 3'b000};
  assign b_nib = b_q[NIBBLE*idx_q +: NIBBLE] ^ {msb, 3'b000};
`else
  assign a_nib = a_q[NIBBLE*idx_q +: NIBBLE];
  assign b_nib = b_q[NIBBLE*idx_q +: NIBBLE];
`endif
  cmp4_unit u_cmp (.a(a_nib), .b(b_nib), .gt(gt), .lt(lt), .eq(eq));
  always_comb begin
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    idx_d = idx_q;
    cnt_d = cnt_q;
    cyc_d = cyc_q;
    gt_d = gt_q;
    lt_d = lt_q;
    eq_d = eq_q;
    case (state_q)
      IDLE: if (start_valid) begin
        a_d = a_in;
        b_d = b_in;
        idx_d = IW'(NIB - 1);
        cnt_d = '0;
        state_d = SCAN;
      end
      SCAN: begin
        cnt_d = cnt_q + CW'(1);
        if (!eq) begin
          {gt_d, lt_d, eq_d} = {gt, lt, 1'b0};
          cyc_d = cnt_q + CW'(1);
          state_d = DONE;
        end else if (idx_q == '0) begin
          {gt_d, lt_d, eq_d} = 3'b001;
          cyc_d = CW'(NIB);
          state_d = DONE;
        end else
          idx_d = idx_q - IW'(1);
      end
      DONE: state_d = res_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      idx_q <= '0;
      cnt_q <= '0;
      cyc_q <= '0;
      gt_q <= 1'b0;
      lt_q <= 1'b0;
      eq_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      idx_q <= idx_d;
      cnt_q <= cnt_d;
      cyc_q <= cyc_d;
      gt_q <= gt_d;
      lt_q <= lt_d;
      eq_q <= eq_d;
    end
  end
  assign start_ready = state_q == IDLE;
  assign res_valid = state_q == DONE;
  assign busy = state_q != IDLE;
  assign a_grt_b = gt_q;
  assign a_less_b = lt_q;
  assign a_eq_b = eq_q;
  assign cmp_cycles = cyc_q;
endmodule
